ahb_slave_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one AHB slave port between up to MASTER_NUM requesting masters. It sits on the slave side of the interconnect, in the slot otherwise occupied by a fixed-priority per-slave arbiter. It holds ownership for the full length of a defined burst by counting accepted beats, caps undefined-length INCR bursts, and rotates priority at every release. It drives the one-hot grant, slave select and master index used by the address/data muxes.

---
 rtl/ahb_slave_rr_scheduler.sv | 98 +++++++++
 tb/tb_ahb_slave_rr_scheduler.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ahb_slave_rr_scheduler.sv
// ahb_slave_rr_scheduler: round-robin owner of one AHB slave port with burst-length hold and INCR capping
module ahb_slave_rr_scheduler #(
  parameter int MASTER_NUM = 4,
  parameter int IDX_W      = $clog2(MASTER_NUM),
  parameter int MAX_HOLD   = 16
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic [MASTER_NUM-1:0] hreq,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hburst,
  input  logic                  hready,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic                  hsel,
  output logic [IDX_W-1:0]      hmaster,
  output logic                  hlast
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANTED = 2'd1;
  localparam logic [1:0] S_BURST   = 2'd2;
  localparam logic [1:0] S_INCR    = 2'd3;
  logic [1:0]       st, st_n;
  logic [IDX_W-1:0] ptr, base, win;
  logic [3:0]       rem, rem_n, len;
  logic [7:0]       hold, hold_n;
  logic             rel, nonseq, seq;
  assign nonseq = hready && htrans == 2'b10;
  assign seq    = hready && htrans == 2'b11;
  assign len    = hburst[2:1] == 2'd1 ? 4'd3 : hburst[2:1] == 2'd2 ? 4'd7 : 4'd15;
  assign hsel   = |hgrant;
  // Winner search starts after the last owner; on a release the current owner becomes that reference
  always_comb begin
    base = st == S_IDLE ? ptr : hmaster;
    win  = base;
    for (int k = MASTER_NUM; k >= 1; k--)
      if (hreq[(int'(base) + k) % MASTER_NUM]) win = IDX_W'((int'(base) + k) % MASTER_NUM);
  end
  // Ownership tracking: decides release and whether it was caused by an accepted beat
  always_comb begin
    st_n   = st;
    rem_n  = rem;
    hold_n = hold;
    rel    = 1'b0;
    hlast  = 1'b0;
    case (st)
      S_IDLE: st_n = |hreq ? S_GRANTED : S_IDLE;
      S_BURST:
        if (seq) begin
          if (rem == 4'd1) {rel, hlast} = 2'b11;
          else rem_n = rem - 4'd1;
        end
      default: begin
        if (st == S_INCR && htrans == 2'b00 && hready) rel = 1'b1;
        else if (nonseq) begin
          if (hburst == 3'd0) {rel, hlast} = 2'b11;
          else if (hburst == 3'd1) begin
            if (MAX_HOLD == 1) {rel, hlast} = 2'b11;
            else begin
              st_n   = S_INCR;
              hold_n = 8'd1;
            end
          end else begin
            st_n  = S_BURST;
            rem_n = len;
          end
        end else if (st == S_INCR && seq) begin
          if (hold + 8'd1 == 8'(MAX_HOLD)) {rel, hlast} = 2'b11;
          else hold_n = hold + 8'd1;
        end else if (st == S_GRANTED && !hreq[hmaster] && htrans == 2'b00) rel = 1'b1;
      end
    endcase
    if (rel) begin
      st_n   = |hreq ? S_GRANTED : S_IDLE;
      rem_n  = 4'd0;
      hold_n = 8'd0;
    end
  end
  // State, pointer and grant registers; a release hands over in the same edge when anyone requests
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      st      <= S_IDLE;
      ptr     <= IDX_W'(MASTER_NUM - 1);
      rem     <= 4'd0;
      hold    <= 8'd0;
      hgrant  <= '0;
      hmaster <= '0;
    end else begin
      st   <= st_n;
      rem  <= rem_n;
      hold <= hold_n;
      if (rel) ptr <= hmaster;
      if (st == S_IDLE || rel) begin
        hgrant <= |hreq ? MASTER_NUM'(1) << win : '0;
        if (|hreq) hmaster <= win;
      end
    end
  end
endmodule

// File: tb/tb_ahb_slave_rr_scheduler.sv
// tb_ahb_slave_rr_scheduler: directed checks of rotation, burst hold, INCR cap, drop release and async reset
module tb_ahb_slave_rr_scheduler;
  logic       hclk = 1'b0;
  logic       hreset_n = 1'b0;
  logic [3:0] hreq = '0;
  logic [1:0] htrans = 2'b00;
  logic [2:0] hburst = 3'd0;
  logic       hready = 1'b1;
  logic [3:0] hgrant;
  logic       hsel;
  logic [1:0] hmaster;
  logic       hlast;
  int         n_run = 0;
  int         n_fail = 0;
  ahb_slave_rr_scheduler dut (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .htrans(htrans), .hburst(hburst),
    .hready(hready), .hgrant(hgrant), .hsel(hsel), .hmaster(hmaster), .hlast(hlast)
  );
  always #5 hclk = ~hclk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge hclk);
    #1;
  endtask
  initial begin
    #2;
    check("rst_hgrant", 16'(hgrant), 16'h0);
    check("rst_hsel", 16'(hsel), 16'h0);
    check("rst_hmaster", 16'(hmaster), 16'h0);
    check("rst_hlast", 16'(hlast), 16'h0);
    step;
    hreset_n = 1'b1;
    hreq = 4'b1111;
    step;
    htrans = 2'b10;
    hburst = 3'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("rr_grant%0d", i), 16'(hgrant), 16'(4'b0001 << (i % 4)));
      check($sformatf("rr_master%0d", i), 16'(hmaster), 16'(i % 4));
      check($sformatf("rr_last%0d", i), 16'(hlast), 16'h1);
      step;
    end
    hreq = 4'b0000;
    htrans = 2'b00;
    #1;
    check("drop_idle_last", 16'(hlast), 16'h0);
    step;
    check("idle_grant", 16'(hgrant), 16'h0);
    check("idle_hsel", 16'(hsel), 16'h0);
    hreq = 4'b0010;
    step;
    check("incr8_grant", 16'(hgrant), 16'h2);
    check("incr8_master", 16'(hmaster), 16'h1);
    for (int b = 1; b <= 8; b++) begin
      htrans = b == 1 ? 2'b10 : 2'b11;
      hburst = b == 1 ? 3'd5 : 3'd0;
      if (b == 3) hreq = 4'b0110;
      if (b == 5) begin
        hready = 1'b0;
        for (int w = 0; w < 2; w++) begin
          #1;
          check($sformatf("incr8_wait_last%0d", w), 16'(hlast), 16'h0);
          step;
          check($sformatf("incr8_wait_grant%0d", w), 16'(hgrant), 16'h2);
        end
        hready = 1'b1;
      end
      #1;
      check($sformatf("incr8_last%0d", b), 16'(hlast), 16'(b == 8));
      check($sformatf("incr8_hold%0d", b), 16'(hgrant), 16'h2);
      step;
    end
    check("incr8_handover", 16'(hgrant), 16'h4);
    hreq = 4'b0001;
    htrans = 2'b00;
    #1;
    check("drop2_last", 16'(hlast), 16'h0);
    step;
    check("incr_grant0", 16'(hgrant), 16'h1);
    hreq = 4'b1001;
    for (int b = 1; b <= 16; b++) begin
      htrans = b == 1 ? 2'b10 : 2'b11;
      hburst = b == 1 ? 3'd1 : 3'd7;
      #1;
      check($sformatf("incr_last%0d", b), 16'(hlast), 16'(b == 16));
      check($sformatf("incr_hold%0d", b), 16'(hgrant), 16'h1);
      step;
    end
    check("incr_cap_grant", 16'(hgrant), 16'h8);
    hreq = 4'b0100;
    htrans = 2'b00;
    step;
    check("to_m2_grant", 16'(hgrant), 16'h4);
    hreq = 4'b1001;
    #1;
    check("m2_drop_last", 16'(hlast), 16'h0);
    step;
    check("m2_drop_next3", 16'(hgrant), 16'h8);
    check("m2_drop_master", 16'(hmaster), 16'h3);
    htrans = 2'b10;
    hburst = 3'd0;
    step;
    check("m3_then0", 16'(hgrant), 16'h1);
    hreq = 4'b0001;
    for (int b = 1; b <= 4; b++) begin
      htrans = b == 1 ? 2'b10 : 2'b11;
      hburst = 3'd6;
      #1;
      check($sformatf("wrap16_last%0d", b), 16'(hlast), 16'h0);
      step;
    end
    htrans = 2'b11;
    #1;
    hreset_n = 1'b0;
    #1;
    check("async_rst_grant", 16'(hgrant), 16'h0);
    check("async_rst_hsel", 16'(hsel), 16'h0);
    check("async_rst_master", 16'(hmaster), 16'h0);
    step;
    step;
    htrans = 2'b00;
    hreq = 4'b0110;
    hreset_n = 1'b1;
    #1;
    check("post_rst_idle", 16'(hgrant), 16'h0);
    step;
    check("post_rst_grant", 16'(hgrant), 16'h2);
    check("post_rst_master", 16'(hmaster), 16'h1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
